// File: rtl/key_pkg.sv
// Shared definitions for the calculator key path.
// Includes the debouncer state encoding and the debounce clock rate.
package key_pkg;

  localparam int DB_CLK_HZ = 100;
  localparam int CNT_W     = 8;

  localparam logic [1:0] KD_IDLE         = 2'd0;
  localparam logic [1:0] KD_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] KD_PRESSED      = 2'd2;
  localparam logic [1:0] KD_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = KD_IDLE,
    ST_PRESS_WAIT   = KD_PRESS_WAIT,
    ST_PRESSED      = KD_PRESSED,
    ST_RELEASE_WAIT = KD_RELEASE_WAIT
  } kd_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input.
// The reset value is a parameter, so the output idles at the input's inactive level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debouncer.sv
// Debounces one raw mechanical key into a clean level with press and release pulses.
// A level change is accepted after STABLE_CNT consecutive equal synchronised samples.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk_db,
  input  logic rst,
  input  logic key_raw,
  output logic btn_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             w_sync;
  logic             w_key;
  kd_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_btn, w_btn_next;
  logic             r_press, w_press_next;
  logic             r_rel, w_rel_next;

  // Synchroniser idles at the unpressed raw level so reset never looks like a press.
  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk_db),
    .rst (rst),
    .i_d (key_raw),
    .o_q (w_sync)
  );

  assign w_key = w_sync ^ ACTIVE_LOW;

  always_ff @(posedge clk_db or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_btn   <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_btn   <= w_btn_next;
      r_press <= w_press_next;
      r_rel   <= w_rel_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_btn_next   = r_btn;
    w_press_next = 1'b0;
    w_rel_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_btn_next = 1'b0;
        if (w_key) begin
          w_state_next = ST_PRESS_WAIT;
          w_cnt_next   = CNT_W'(1);
        end else begin
          w_cnt_next   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_key) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ST_PRESSED;
          w_btn_next   = 1'b1;
          w_press_next = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        w_btn_next = 1'b1;
        if (!w_key) begin
          w_state_next = ST_RELEASE_WAIT;
          w_cnt_next   = CNT_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        // A pressed sample here is a release bounce: return without a pulse.
        if (w_key) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ST_IDLE;
          w_btn_next   = 1'b0;
          w_rel_next   = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_btn_next   = 1'b0;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign btn_out       = r_btn;
  assign press_pulse   = r_press;
  assign release_pulse = r_rel;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: an active-low STABLE_CNT=3 instance and an
// active-high STABLE_CNT=2 instance share one logical key stimulus.
module tb_key_debouncer;

  logic clk_db = 1'b0;
  logic rst;
  logic key_raw;
  logic key_raw_n;
  logic btn0, prs0, rel0;
  logic btn1, prs1, rel1;

  int n_cmp = 0;
  int n_err = 0;

  assign key_raw_n = ~key_raw;

  always #5 clk_db = ~clk_db;

  key_debouncer #(.STABLE_CNT(3), .ACTIVE_LOW(1'b1)) dut0 (
    .clk_db        (clk_db),
    .rst           (rst),
    .key_raw       (key_raw),
    .btn_out       (btn0),
    .press_pulse   (prs0),
    .release_pulse (rel0)
  );

  key_debouncer #(.STABLE_CNT(2), .ACTIVE_LOW(1'b0)) dut1 (
    .clk_db        (clk_db),
    .rst           (rst),
    .key_raw       (key_raw_n),
    .btn_out       (btn1),
    .press_pulse   (prs1),
    .release_pulse (rel1)
  );

  task automatic kd_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[%0t] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", $time, tag, got, got, exp, exp);
    end
  endtask

  // Reference model: run length of samples that disagree with the accepted level.
  logic [5:0] exp_q[$];
  int         cyc = 0;
  logic       m_s1 = 1'b0, m_s2 = 1'b0;
  logic       m_btn[2];
  logic       m_prs[2];
  logic       m_rel[2];
  int         m_run[2];

  always @(posedge clk_db) begin
    logic k;
    cyc++;
    if (rst) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_btn[d] = 1'b0; m_prs[d] = 1'b0; m_rel[d] = 1'b0; m_run[d] = 0;
      end
    end else begin
      k    = m_s2;
      m_s2 = m_s1;
      m_s1 = ~key_raw;
      for (int d = 0; d < 2; d++) begin
        m_prs[d] = 1'b0;
        m_rel[d] = 1'b0;
        if (k != m_btn[d]) begin
          m_run[d]++;
          if (m_run[d] == ((d == 0) ? 3 : 2)) begin
            m_btn[d] = k;
            m_prs[d] = k;
            m_rel[d] = ~k;
            m_run[d] = 0;
          end
        end else begin
          m_run[d] = 0;
        end
      end
    end
    exp_q.push_back({m_rel[1], m_prs[1], m_btn[1], m_rel[0], m_prs[0], m_btn[0]});
  end

  // Monitor: scoreboard compare, pulse alternation, edge timestamps.
  int   rise_cyc[2] = '{-1, -1};
  int   fall_cyc[2] = '{-1, -1};
  int   prs_cnt[2]  = '{0, 0};
  int   rel_cnt[2]  = '{0, 0};
  logic last_prs[2] = '{1'b0, 1'b0};
  logic prev_btn[2] = '{1'b0, 1'b0};

  always @(negedge clk_db) begin
    logic [5:0] got, exp;
    logic b, p, r;
    got = {rel1, prs1, btn1, rel0, prs0, btn0};
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      kd_check("scoreboard", 32'(got), 32'(exp));
    end
    for (int d = 0; d < 2; d++) begin
      b = (d == 0) ? btn0 : btn1;
      p = (d == 0) ? prs0 : prs1;
      r = (d == 0) ? rel0 : rel1;
      if (rst) begin
        last_prs[d] = 1'b0;
      end else begin
        if (p) begin
          kd_check("alt_press", 32'(last_prs[d]), 32'(0));
          last_prs[d] = 1'b1;
          prs_cnt[d]++;
          $display("[%0t] cyc %0d dut%0d press_pulse", $time, cyc, d);
        end
        if (r) begin
          kd_check("alt_release", 32'(last_prs[d]), 32'(1));
          last_prs[d] = 1'b0;
          rel_cnt[d]++;
          $display("[%0t] cyc %0d dut%0d release_pulse", $time, cyc, d);
        end
      end
      if (b && !prev_btn[d]) rise_cyc[d] = cyc;
      if (!b && prev_btn[d]) fall_cyc[d] = cyc;
      prev_btn[d] = b;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_db);
  endtask

  logic [5:0] bounce;
  int         e0;

  initial begin
    rst     = 1'b1;
    key_raw = 1'b1;
    step(3);
    #1 rst = 1'b0;

    // Idle after reset with the key released.
    step(20);
    #2 kd_check("idle_press_cnt", 32'(prs_cnt[0] + prs_cnt[1]), 32'(0));
    kd_check("idle_btn", 32'({btn1, btn0}), 32'(0));

    // Clean press held for a long time.
    step(1); key_raw = 1'b0; e0 = cyc + 1;
    step(200);
    #2 kd_check("press_lat0", 32'(rise_cyc[0] - e0), 32'(4));
    kd_check("press_lat1", 32'(rise_cyc[1] - e0), 32'(3));
    kd_check("press_once0", 32'(prs_cnt[0]), 32'(1));
    kd_check("press_once1", 32'(prs_cnt[1]), 32'(1));

    // Two-sample release glitch.
    step(1); key_raw = 1'b1;
    step(2); key_raw = 1'b0;
    step(12);
    #2 kd_check("glitch_btn0", 32'(btn0), 32'(1));
    kd_check("glitch_rel0", 32'(rel_cnt[0]), 32'(0));

    // Clean release.
    step(1); key_raw = 1'b1; e0 = cyc + 1;
    step(20);
    #2 kd_check("release_lat0", 32'(fall_cyc[0] - e0), 32'(4));
    kd_check("release_lat1", 32'(fall_cyc[1] - e0), 32'(3));
    kd_check("release_once0", 32'(rel_cnt[0]), 32'(1));

    // Bouncing press: 0,1,0,0,1,0 then steady 0.
    bounce = 6'b010010;
    for (int i = 0; i < 6; i++) begin
      step(1); key_raw = bounce[5-i];
    end
    e0 = cyc + 1;
    step(30);
    #2 kd_check("bounce_lat0", 32'(rise_cyc[0] - e0), 32'(4));
    kd_check("bounce_press0", 32'(prs_cnt[0]), 32'(2));
    step(1); key_raw = 1'b1;
    step(20);

    // Reset while both instances sit in PRESS_WAIT with cnt=1.
    step(1); key_raw = 1'b0;
    step(3);
    #1 rst = 1'b1;
    #1 kd_check("rst_mid_out", 32'({rel1, prs1, btn1, rel0, prs0, btn0}), 32'(0));
    step(1);
    #1 rst = 1'b0; e0 = cyc + 1;
    step(20);
    #2 kd_check("rst_lat0", 32'(rise_cyc[0] - e0), 32'(4));
    kd_check("rst_lat1", 32'(rise_cyc[1] - e0), 32'(3));

    // Asynchronous reset while pressed clears outputs without a clock edge.
    step(1);
    #1 rst = 1'b1;
    #1 kd_check("rst_async_out", 32'({rel1, prs1, btn1, rel0, prs0, btn0}), 32'(0));
    step(1);
    #1 rst = 1'b0;
    step(20);
    step(1); key_raw = 1'b1;
    step(20);
    #2 kd_check("final_btn", 32'({btn1, btn0}), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Upstream stage of the calculator key path. Takes a raw, bouncing mechanical key input and produces a clean debounced level for the long/short press classifier.
- Also produces single-cycle press and release edge pulses.
- Runs on the 100 Hz debounce clock. Contains a 2-flop synchroniser, a stability counter and a 4-state FSM.
- One instance per key.

Parameters:
- STABLE_CNT, 3: consecutive equal synchronised samples required to accept a level change. Legal range 2..255; the default gives 30 ms at 100 Hz.
- ACTIVE_LOW, 1: 1 means the raw key reads 0 when pressed and is inverted internally. 0 means the raw key reads 1 when pressed.

Ports:
- clk_db  input  1  debounce clock (100 Hz).
- rst  input  1  reset; one clock, asynchronous, active-high.
- key_raw  input  1  raw asynchronous key pin.
- btn_out  output  1  debounced level, 1 = pressed. Drives the classifier's btn_in.
- press_pulse  output  1  one-cycle pulse in the cycle btn_out rises.
- release_pulse  output  1  one-cycle pulse in the cycle btn_out falls.

Behaviour:
- Reset (async, rst=1):
  - sync_1 and sync_2 go to the unpressed raw level (1 if ACTIVE_LOW, else 0).
  - cnt=0, state=IDLE.
  - btn_out=0, press_pulse=0, release_pulse=0.
  - rst asserted mid-debounce discards the partial count. No pulse is emitted on reset entry or exit.
- Synchroniser: key_raw -> sync_1 -> sync_2.
  - key = sync_2 XOR ACTIVE_LOW, so key is 1 when pressed.
- All outputs are registered. press_pulse and release_pulse default to 0 every cycle.
- cnt is 8 bits. It only increments while below STABLE_CNT-1, so it never wraps.
- FSM, evaluated on each posedge clk_db:
  - IDLE (btn_out=0): key=1 -> PRESS_WAIT, cnt<=1. Otherwise stay, cnt<=0.
  - PRESS_WAIT:
    - key=0 -> IDLE, cnt<=0 (bounce rejected, no pulse).
    - key=1 and cnt==STABLE_CNT-1 -> PRESSED, btn_out<=1, press_pulse<=1, cnt<=0.
    - Otherwise cnt<=cnt+1.
  - PRESSED (btn_out=1): key=0 -> RELEASE_WAIT, cnt<=1. Otherwise stay.
  - RELEASE_WAIT:
    - key=1 -> PRESSED, cnt<=0. btn_out stays 1, no pulse.
    - key=0 and cnt==STABLE_CNT-1 -> IDLE, btn_out<=0, release_pulse<=1, cnt<=0.
    - Otherwise cnt<=cnt+1.
- Latency:
  - Raw level stable from before edge e0: sync_1 captures at e0, sync_2 at e1.
  - btn_out changes on edge e0+STABLE_CNT+1. That is the (STABLE_CNT+2)-th edge counting e0; with the default, the 5th edge.
  - The pulse is asserted for exactly the one cycle following that edge.
- Boundaries:
  - A glitch shorter than STABLE_CNT synchronised samples never changes btn_out.
  - press_pulse and release_pulse are never high together.
  - The two pulses strictly alternate, starting with press after reset.
  - A key held indefinitely gives btn_out=1 forever, with no repeated pulses.
  - Unused state encodings recover to IDLE with btn_out=0.

Decomposition:
- Shared package key_pkg holds:
  - state encoding localparams: KD_IDLE=2'd0, KD_PRESS_WAIT=2'd1, KD_PRESSED=2'd2, KD_RELEASE_WAIT=2'd3.
  - the constant DB_CLK_HZ=100, which the long-press threshold also uses.
- One natural sub-module: sync_2ff, the 2-flop synchroniser with a parameterised reset value. It is reusable for other asynchronous calculator inputs.
- The FSM and counter stay inline.

Test Plan:
1. Reset release with key_raw=1 (ACTIVE_LOW=1, unpressed): hold 20 cycles -> btn_out, press_pulse and release_pulse all 0 throughout.
2. Clean press: key_raw 1->0 before edge e0 and held -> btn_out=1 from edge e0+4, press_pulse=1 for exactly that one cycle. Hold 200 cycles -> no further pulses.
3. Bounce on press: key_raw pattern 0,1,0,0,1,0 (one value per cycle) then steady 0 -> no pulse during bounce. btn_out rises 5 edges after the final 1->0 transition. Exactly one press_pulse.
4. Release glitch: in PRESSED, key_raw goes 1 for 2 cycles then back to 0 -> btn_out stays 1, no release_pulse.
5. Clean release: after (2), key_raw 0->1 held -> btn_out=0 five edges later, release_pulse single cycle. The pulse order observed overall is press, release.
6. Reset mid-debounce: assert rst while in PRESS_WAIT with cnt=1 -> all outputs 0 immediately (async). After deassert with the key still pressed, a full STABLE_CNT+2-edge latency is required before btn_out=1. STABLE_CNT=2 override: btn_out rises on the 4th edge.
